// File: rtl/vend_pkg.sv
// +--------------------------------------------------------------------+
// | vend_pkg                                                           |
// | Shared types, widths and defaults for the vending sequencer.       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

package vend_pkg;

  localparam int unsigned c_credit_w = 5;
  localparam int unsigned c_price_w  = 4;
  localparam int unsigned c_stock_w  = 3;
  localparam int unsigned c_n_prod   = 4;
  localparam int unsigned c_sel_w    = 2;

  localparam int unsigned c_credit_max_def = 20;
  localparam int unsigned c_stock_init_def = 7;
  localparam int unsigned c_price_init_def = 5;

  localparam logic [1:0] c_coin_one  = 2'd2;
  localparam logic [1:0] c_coin_half = 2'd1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_VEND    = 2'd2,
    ST_CHANGE  = 2'd3
  } vend_state_t;

  function automatic logic [1:0] coin_value(input logic one, input logic half);
    return (one ? c_coin_one : 2'd0) + (half ? c_coin_half : 2'd0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/vend_stock.sv
// +--------------------------------------------------------------------+
// | vend_stock                                                         |
// | Per-product stock counters with restock and empty flags.           |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module vend_stock
  import vend_pkg::*;
#(
  parameter int unsigned STOCK_INIT = c_stock_init_def
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 i_restock,
  input  logic                 i_dec,
  input  logic [c_sel_w-1:0]   i_dec_id,
  output logic [c_n_prod-1:0]  o_empty
);

  localparam logic [c_stock_w-1:0] c_stock_init = STOCK_INIT[c_stock_w-1:0];

  logic [c_stock_w-1:0] r_stock [c_n_prod];

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < c_n_prod; i++) r_stock[i] <= c_stock_init;
    end else if (i_restock) begin
      for (int i = 0; i < c_n_prod; i++) r_stock[i] <= c_stock_init;
    end else if (i_dec && (r_stock[i_dec_id] != '0)) begin
      r_stock[i_dec_id] <= r_stock[i_dec_id] - 1'b1;
    end
  end

  generate
    for (genvar g = 0; g < c_n_prod; g++) begin : g_empty
      assign o_empty[g] = (r_stock[g] == '0);
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/vend_seq_ctrl.sv
// +--------------------------------------------------------------------+
// | vend_seq_ctrl                                                      |
// | Coin-operated four-product vending sequencer with change return.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module vend_seq_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned CREDIT_MAX = c_credit_max_def,
  parameter int unsigned STOCK_INIT = c_stock_init_def,
  parameter int unsigned PRICE_INIT = c_price_init_def
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic                   pi_money_one,
  input  logic                   pi_money_half,
  input  logic                   pi_sel_vld,
  input  logic [c_sel_w-1:0]     pi_sel,
  input  logic                   pi_cancel,
  input  logic                   cfg_we,
  input  logic [c_sel_w-1:0]     cfg_addr,
  input  logic [c_price_w-1:0]   cfg_price,
  input  logic                   pi_restock,
  output logic                   po_beverage,
  output logic [c_sel_w-1:0]     po_bev_id,
  output logic                   po_money,
  output logic                   po_coin_rej,
  output logic                   po_sel_err,
  output logic [c_credit_w-1:0]  po_credit,
  output logic [c_n_prod-1:0]    po_empty,
  output logic                   po_busy
);

  localparam logic [c_credit_w:0]   c_credit_max = CREDIT_MAX[c_credit_w:0];
  localparam logic [c_price_w-1:0]  c_price_init = PRICE_INIT[c_price_w-1:0];

  vend_state_t             r_state;
  vend_state_t             w_state_nxt;
  logic [c_credit_w-1:0]   r_credit;
  logic [c_credit_w-1:0]   w_credit_nxt;
  logic [c_price_w-1:0]    r_price [c_n_prod];
  logic [c_sel_w-1:0]      r_bev_id;
  logic                    r_bev;
  logic                    r_money;
  logic                    r_busy;
  logic                    r_coin_rej;
  logic                    r_sel_err;

  logic                    w_coin_evt;
  logic [1:0]              w_coin_val;
  logic [c_credit_w:0]     w_credit_sum;
  logic                    w_coin_fits;
  logic                    w_sel_ok;
  logic [c_n_prod-1:0]     w_empty;
  logic                    w_coin_rej;
  logic                    w_sel_err;
  logic                    w_sel_acc;
  logic                    w_dec;
  logic                    w_cfg_wr;
  logic                    w_restock;

  assign w_coin_evt   = pi_money_one | pi_money_half;
  assign w_coin_val   = coin_value(pi_money_one, pi_money_half);
  assign w_credit_sum = {1'b0, r_credit} + {{(c_credit_w-1){1'b0}}, w_coin_val};
  assign w_coin_fits  = (w_credit_sum <= c_credit_max);
  assign w_sel_ok     = !w_empty[pi_sel] && (r_credit >= {1'b0, r_price[pi_sel]});

  always_comb begin
    w_state_nxt  = r_state;
    w_credit_nxt = r_credit;
    w_coin_rej   = 1'b0;
    w_sel_err    = 1'b0;
    w_sel_acc    = 1'b0;
    w_dec        = 1'b0;
    w_cfg_wr     = 1'b0;
    w_restock    = 1'b0;

    case (r_state)
      ST_IDLE, ST_COLLECT: begin
        w_restock = pi_restock;
        w_cfg_wr  = (r_state == ST_IDLE) && cfg_we && (cfg_price != '0);
        if ((r_state == ST_COLLECT) && pi_cancel) begin
          w_state_nxt = ST_CHANGE;
          w_coin_rej  = w_coin_evt;
        end else if ((r_state == ST_COLLECT) && pi_sel_vld && w_sel_ok) begin
          w_state_nxt = ST_VEND;
          w_sel_acc   = 1'b1;
          w_coin_rej  = w_coin_evt;
        end else begin
          w_sel_err = pi_sel_vld;
          if (w_coin_evt) begin
            if (w_coin_fits) begin
              w_credit_nxt = w_credit_sum[c_credit_w-1:0];
              w_state_nxt  = ST_COLLECT;
            end else begin
              w_coin_rej = 1'b1;
            end
          end
        end
      end
      ST_VEND: begin
        w_dec        = 1'b1;
        w_coin_rej   = w_coin_evt;
        w_sel_err    = pi_sel_vld;
        w_credit_nxt = r_credit - {1'b0, r_price[r_bev_id]};
        w_state_nxt  = (w_credit_nxt != '0) ? ST_CHANGE : ST_IDLE;
      end
      ST_CHANGE: begin
        w_coin_rej = w_coin_evt;
        w_sel_err  = pi_sel_vld;
        // Saturate so a zero-credit entry can never wrap into a long refund.
        if (r_credit <= 1) begin
          w_credit_nxt = '0;
          w_state_nxt  = ST_IDLE;
        end else begin
          w_credit_nxt = r_credit - 1'b1;
        end
      end
      default: begin
        w_state_nxt  = ST_IDLE;
        w_credit_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state    <= ST_IDLE;
      r_credit   <= '0;
      r_bev      <= 1'b0;
      r_bev_id   <= '0;
      r_money    <= 1'b0;
      r_busy     <= 1'b0;
      r_coin_rej <= 1'b0;
      r_sel_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_credit   <= w_credit_nxt;
      r_bev      <= (w_state_nxt == ST_VEND);
      r_money    <= (w_state_nxt == ST_CHANGE);
      r_busy     <= (w_state_nxt == ST_VEND) || (w_state_nxt == ST_CHANGE);
      r_coin_rej <= w_coin_rej;
      r_sel_err  <= w_sel_err;
      if (w_sel_acc) r_bev_id <= pi_sel;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < c_n_prod; i++) r_price[i] <= c_price_init;
    end else if (w_cfg_wr) begin
      r_price[cfg_addr] <= cfg_price;
    end
  end

  vend_stock #(
    .STOCK_INIT (STOCK_INIT)
  ) u_stock (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .i_restock (w_restock),
    .i_dec     (w_dec),
    .i_dec_id  (r_bev_id),
    .o_empty   (w_empty)
  );

  assign po_beverage = r_bev;
  assign po_bev_id   = r_bev_id;
  assign po_money    = r_money;
  assign po_coin_rej = r_coin_rej;
  assign po_sel_err  = r_sel_err;
  assign po_credit   = r_credit;
  assign po_empty    = w_empty;
  assign po_busy     = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_vend_seq_ctrl.sv
// +--------------------------------------------------------------------+
// | tb_vend_seq_ctrl                                                   |
// | Directed vector table plus corner-case sequences for vend_seq_ctrl.|
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_vend_seq_ctrl;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       pi_money_one, pi_money_half, pi_sel_vld, pi_cancel;
  logic [1:0] pi_sel;
  logic       cfg_we;
  logic [1:0] cfg_addr;
  logic [3:0] cfg_price;
  logic       pi_restock;
  logic       po_beverage, po_money, po_coin_rej, po_sel_err, po_busy;
  logic [1:0] po_bev_id;
  logic [4:0] po_credit;
  logic [3:0] po_empty;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct packed {
    logic       one;
    logic       half;
    logic       sel_vld;
    logic [1:0] sel;
    logic       cancel;
    logic       cfg_we;
    logic [1:0] cfg_addr;
    logic [3:0] cfg_price;
    logic       restock;
  } in_t;

  typedef struct packed {
    logic       bev;
    logic [1:0] bev_id;
    logic       money;
    logic       rej;
    logic       err;
    logic       busy;
    logic [4:0] credit;
    logic [3:0] empty;
  } out_t;

  typedef struct {
    in_t  i;
    out_t o;
  } vec_t;

  vec_t vecs[$];

  vend_seq_ctrl dut (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .pi_money_one  (pi_money_one),
    .pi_money_half (pi_money_half),
    .pi_sel_vld    (pi_sel_vld),
    .pi_sel        (pi_sel),
    .pi_cancel     (pi_cancel),
    .cfg_we        (cfg_we),
    .cfg_addr      (cfg_addr),
    .cfg_price     (cfg_price),
    .pi_restock    (pi_restock),
    .po_beverage   (po_beverage),
    .po_bev_id     (po_bev_id),
    .po_money      (po_money),
    .po_coin_rej   (po_coin_rej),
    .po_sel_err    (po_sel_err),
    .po_credit     (po_credit),
    .po_empty      (po_empty),
    .po_busy       (po_busy)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic in_t vi(input logic one, input logic half, input logic sv,
                             input logic [1:0] s, input logic can);
    in_t v;
    v = '0;
    v.one = one; v.half = half; v.sel_vld = sv; v.sel = s; v.cancel = can;
    return v;
  endfunction

  function automatic in_t vc(input logic [1:0] addr, input logic [3:0] price);
    in_t v;
    v = '0;
    v.cfg_we = 1'b1; v.cfg_addr = addr; v.cfg_price = price;
    return v;
  endfunction

  function automatic out_t vo(input logic bev, input logic [1:0] id, input logic money,
                              input logic rej, input logic err, input logic busy,
                              input logic [4:0] credit);
    out_t o;
    o = '0;
    o.bev = bev; o.bev_id = id; o.money = money; o.rej = rej;
    o.err = err; o.busy = busy; o.credit = credit;
    return o;
  endfunction

  function automatic out_t sample();
    return {po_beverage, po_bev_id, po_money, po_coin_rej, po_sel_err,
            po_busy, po_credit, po_empty};
  endfunction

  task automatic add(input in_t i, input out_t o);
    vec_t v;
    v.i = i;
    v.o = o;
    vecs.push_back(v);
  endtask

  task automatic drive(input in_t v);
    pi_money_one  = v.one;
    pi_money_half = v.half;
    pi_sel_vld    = v.sel_vld;
    pi_sel        = v.sel;
    pi_cancel     = v.cancel;
    cfg_we        = v.cfg_we;
    cfg_addr      = v.cfg_addr;
    cfg_price     = v.cfg_price;
    pi_restock    = v.restock;
  endtask

  task automatic clr();
    drive('0);
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic coin(input logic one, input logic half);
    pi_money_one = one; pi_money_half = half;
    tick();
    clr();
  endtask

  task automatic select(input logic [1:0] s);
    pi_sel_vld = 1'b1; pi_sel = s;
    tick();
    clr();
  endtask

  task automatic wait_idle(input int max_cycles);
    int c;
    c = 0;
    while (po_busy && c < max_cycles) begin
      tick();
      c++;
    end
    chk("wait_idle_busy", {31'b0, po_busy}, 32'd0);
  endtask

  initial begin
    int n_money, n_bev, runs, sales_ok;
    logic prev;
    in_t i0;
    i0 = '0;

    // one, one, half then select 0 with a coin in the same cycle
    add(vi(1,0,0,0,0), vo(0,0,0,0,0,0,2));
    add(vi(1,0,0,0,0), vo(0,0,0,0,0,0,4));
    add(vi(0,1,0,0,0), vo(0,0,0,0,0,0,5));
    add(vi(0,1,1,0,0), vo(1,0,0,1,0,1,5));
    add(i0,            vo(0,0,0,0,0,0,0));
    add(i0,            vo(0,0,0,0,0,0,0));
    // credit 8, product 2 at price 5 -> 3 change pulses; coin during VEND refused
    for (int k = 1; k <= 4; k++) add(vi(1,0,0,0,0), vo(0,0,0,0,0,0,5'(2*k)));
    add(vi(0,0,1,2,0), vo(1,2,0,0,0,1,8));
    add(vi(1,0,0,0,0), vo(0,2,1,1,0,1,3));
    add(i0,            vo(0,2,1,0,0,1,2));
    add(i0,            vo(0,2,1,0,0,1,1));
    add(i0,            vo(0,2,0,0,0,0,0));
    // select in IDLE, price config in IDLE, zero price ignored
    add(vi(0,0,1,1,0), vo(0,2,0,0,1,0,0));
    add(i0,            vo(0,2,0,0,0,0,0));
    add(vc(3,2),       vo(0,2,0,0,0,0,0));
    add(vc(3,0),       vo(0,2,0,0,0,0,0));
    add(vi(0,1,0,0,0), vo(0,2,0,0,0,0,1));
    add(vi(0,1,0,0,0), vo(0,2,0,0,0,0,2));
    add(vi(0,0,1,3,0), vo(1,3,0,0,0,1,2));
    add(i0,            vo(0,3,0,0,0,0,0));
    // config ignored in COLLECT, underfunded select, cancel with 1 half-unit
    add(vi(0,1,0,0,0), vo(0,3,0,0,0,0,1));
    add(vc(0,1),       vo(0,3,0,0,0,0,1));
    add(vi(0,0,1,0,0), vo(0,3,0,0,1,0,1));
    add(vi(0,0,0,0,1), vo(0,3,1,0,0,1,1));
    add(i0,            vo(0,3,0,0,0,0,0));
    // credit 19, one refused, half fills to 20, then full refund of 20
    for (int k = 1; k <= 9; k++) add(vi(1,0,0,0,0), vo(0,3,0,0,0,0,5'(2*k)));
    add(vi(0,1,0,0,0), vo(0,3,0,0,0,0,19));
    add(vi(1,0,0,0,0), vo(0,3,0,1,0,0,19));
    add(vi(0,1,0,0,0), vo(0,3,0,0,0,0,20));
    add(i0,            vo(0,3,0,0,0,0,20));
    add(vi(0,0,0,0,1), vo(0,3,1,0,0,1,20));
    for (int k = 19; k >= 1; k--) add(i0, vo(0,3,1,0,0,1,5'(k)));
    add(i0,            vo(0,3,0,0,0,0,0));

    clr();
    sys_rst_n = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    chk("reset_state", 32'(sample()), 32'd0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    foreach (vecs[k]) begin
      drive(vecs[k].i);
      tick();
      chk($sformatf("vec%0d", k), 32'(sample()), 32'(vecs[k].o));
    end
    clr();

    // cancel and select together with credit 6: refund only
    repeat (3) coin(1, 0);
    chk("pre_cancel_credit", 32'(po_credit), 32'd6);
    pi_cancel = 1'b1; pi_sel_vld = 1'b1; pi_sel = 2'd1;
    tick();
    clr();
    n_money = 0; n_bev = 0; runs = 0; prev = 1'b0;
    for (int c = 0; c < 16 && po_busy; c++) begin
      if (po_money) n_money++;
      if (po_money && !prev) runs++;
      if (po_beverage) n_bev++;
      prev = po_money;
      tick();
    end
    chk("cancel_money_pulses", 32'(n_money), 32'd6);
    chk("cancel_money_runs", 32'(runs), 32'd1);
    chk("cancel_no_beverage", 32'(n_bev), 32'd0);
    chk("cancel_end_state", 32'(sample()), 32'(vo(0,3,0,0,0,0,0)));

    // drain product 1, then refused select, then restock
    sales_ok = 0;
    for (int s = 0; s < 7; s++) begin
      coin(1, 0); coin(1, 0); coin(0, 1);
      select(2'd1);
      if (po_beverage && po_bev_id == 2'd1) sales_ok++;
      tick();
    end
    chk("sell7_count", 32'(sales_ok), 32'd7);
    chk("sell7_empty", 32'(po_empty), 32'h2);
    coin(1, 0); coin(1, 0); coin(0, 1);
    select(2'd1);
    chk("sell8_refused", 32'(sample()), 32'(vo(0,1,0,0,1,0,5)) | 32'h2);
    pi_cancel = 1'b1;
    tick();
    clr();
    wait_idle(10);
    pi_restock = 1'b1;
    tick();
    clr();
    chk("restock_empty", 32'(po_empty), 32'd0);

    // reset while returning change
    coin(1, 0); coin(1, 0);
    pi_cancel = 1'b1;
    tick();
    clr();
    chk("change_before_reset", 32'(sample()), 32'(vo(0,1,1,0,0,1,4)));
    #2 sys_rst_n = 1'b0;
    #1;
    chk("reset_mid_change", 32'(sample()), 32'd0);
    @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    tick();
    chk("after_reset_quiet", 32'(sample()), 32'd0);
    coin(1, 0);
    select(2'd3);
    chk("price_default_err", 32'(sample()), 32'(vo(0,0,0,0,1,0,2)));
    coin(1, 1);
    select(2'd3);
    chk("price_default_vend", 32'(sample()), 32'(vo(1,3,0,0,0,1,5)));
    tick();
    chk("final_idle", 32'(sample()), 32'(vo(0,3,0,0,0,0,0)));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vend_seq_ctrl.md
VEND_SEQ_CTRL -- requirements
Module: vend_seq_ctrl

Interface
REQ-001 SHALL have parameter CREDIT_MAX, default 20, max credit in half-units (10 yuan).
REQ-002 SHALL have parameter STOCK_INIT, default 7, per-product stock after reset/restock (3-bit).
REQ-003 SHALL have parameter PRICE_INIT, default 5, per-product price after reset (half-units).
REQ-004 SHALL have port sys_clk  in  1  clock; all logic on rising edge.
REQ-005 SHALL have port sys_rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port pi_money_one  in  1  1-yuan coin, one-cycle pulse.
REQ-007 SHALL have port pi_money_half  in  1  0.5-yuan coin, one-cycle pulse.
REQ-008 SHALL have port pi_sel_vld  in  1  product select strobe.
REQ-009 SHALL have port pi_sel  in  2  product index 0..3.
REQ-010 SHALL have port pi_cancel  in  1  refund request pulse.
REQ-011 SHALL have port cfg_we  in  1  price write strobe.
REQ-012 SHALL have port cfg_addr  in  2  product index for price write.
REQ-013 SHALL have port cfg_price  in  4  new price, half-units, 1..15.
REQ-014 SHALL have port pi_restock  in  1  reload all stock to STOCK_INIT.
REQ-015 SHALL have port po_beverage  out  1  one-cycle dispense pulse.
REQ-016 SHALL have port po_bev_id  out  2  product dispensed, valid with po_beverage.
REQ-017 SHALL have port po_money  out  1  change pulse, one cycle per 0.5 yuan returned.
REQ-018 SHALL have port po_coin_rej  out  1  one-cycle pulse: coin refused.
REQ-019 SHALL have port po_sel_err  out  1  one-cycle pulse: select refused.
REQ-020 SHALL have port po_credit  out  5  current credit register, half-units.
REQ-021 SHALL have port po_empty  out  4  bit i = product i stock zero.
REQ-022 SHALL have port po_busy  out  1  high in VEND or CHANGE.

Function
REQ-023 SHALL implement states IDLE (credit 0), COLLECT (credit>0), VEND, CHANGE.
REQ-024 SHALL, in IDLE/COLLECT, add coin value (one=2, half=1, both same cycle=3) to credit one cycle after sampling; IDLE->COLLECT on first accepted coin.
REQ-025 SHALL reject the whole coin event (credit unchanged, po_coin_rej next cycle) if credit+value > CREDIT_MAX, or if state is VEND/CHANGE.
REQ-026 SHALL, on pi_sel_vld in COLLECT with stock[pi_sel]>0 and credit>=price[pi_sel], go to VEND; otherwise (incl. IDLE) pulse po_sel_err next cycle, state unchanged.
REQ-027 SHALL, when a coin and a valid select arrive in the same cycle, reject the coin and process the select.
REQ-028 SHALL spend exactly one cycle in VEND: po_beverage=1, po_bev_id=latched sel, stock decremented, credit -= price; next CHANGE if remaining credit>0 else IDLE.
REQ-029 SHALL in CHANGE assert po_money and decrement credit by 1 each cycle; return to IDLE in the cycle credit reaches 0 (N pulses for N half-units, back-to-back).
REQ-030 SHALL on pi_cancel in COLLECT go to CHANGE (full refund); cancel ignored in IDLE/VEND/CHANGE; cancel beats pi_sel_vld and coins in the same cycle (coin rejected).
REQ-031 SHALL apply cfg_we only in IDLE; ignored elsewhere; cfg_price=0 ignored.
REQ-032 SHALL apply pi_restock only in IDLE/COLLECT; takes effect next cycle; same-cycle VEND decrement not possible by construction.
REQ-033 SHALL derive po_empty combinationally from stock registers; all other outputs registered.

Reset
REQ-034 SHALL on sys_rst_n low: state IDLE, credit 0, all prices PRICE_INIT, all stock STOCK_INIT, all pulse outputs 0, po_bev_id 0.
REQ-035 SHALL on reset mid-VEND/CHANGE discard owed change and restore defaults (no output pulse).

Structure
REQ-036 SHALL place state enum, coin values, CREDIT_MAX/STOCK_INIT/PRICE_INIT defaults and credit/price widths in package vend_pkg.
REQ-037 SHALL implement stock counters, restock and po_empty in sub-module vend_stock.

Verification
REQ-038 SHALL test: one, one, half (credit 5), sel 0 price 5 -> po_beverage 1 cycle, bev_id 0, no po_money, IDLE.
REQ-039 SHALL test: credit 8, sel price 5 -> VEND then exactly 3 consecutive po_money pulses, credit 0.
REQ-040 SHALL test: credit 19, pi_money_one -> po_coin_rej, credit stays 19; half -> credit 20.
REQ-041 SHALL test: credit 6, cancel + sel same cycle -> 6 po_money pulses, no po_beverage.
REQ-042 SHALL test: sell product 1 seven times -> po_empty[1]=1, 8th sel -> po_sel_err; restock -> po_empty 0.
REQ-043 SHALL test: reset asserted during CHANGE with credit 4 -> all outputs 0, credit 0, prices/stock default.
